// File: rtl/vin_pattern_gen_pkg.sv
// vin_pattern_gen shared types and constants.
// State/mode encodings, LFSR taps and the LFSR step function.
package vin_pattern_gen_pkg;

   localparam int NB_DEF = 11;

   // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   typedef enum logic [1:0] {
      M_CONT,
      M_ALT,
      M_LFSR,
      M_BURST
   } mode_e;

   function automatic logic [7:0] lfsr_next(
      input logic [7:0] l
   );
      return {l[6:0], ^(l & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/vin_pattern_gen_if.sv
// DIN/VIN stream bundle from the pattern generator to the filter.
// Ports: VOUT, DOUT, c2/c1/c0/b0 coefficients, END_SIM.
interface vin_pattern_gen_if
   import vin_pattern_gen_pkg::*;
#(
   parameter int NB = NB_DEF
) ();

   logic                 VOUT;
   logic signed [NB-1:0] DOUT;
   logic signed [NB-1:0] c2;
   logic signed [NB-1:0] c1;
   logic signed [NB-1:0] c0;
   logic signed [NB-1:0] b0;
   logic                 END_SIM;

   modport master (
      output VOUT, DOUT,
      output c2, c1, c0, b0,
      output END_SIM
   );

   modport slave (
      input VOUT, DOUT,
      input c2, c1, c0, b0,
      input END_SIM
   );

endinterface

// File: rtl/vin_pattern_gen_gap_gen.sv
// Gap pattern source: gate g for continuous/alternate/LFSR/burst.
// Ports: clk, rst_n, mode_i, start_i (run start), adv_i, g_o.
module gap_gen
   import vin_pattern_gen_pkg::*;
#(
   parameter int         BURST = 4,
   parameter logic [7:0] SEED  = 8'hA5
) (
   input  logic  clk,
   input  logic  rst_n,
   input  mode_e mode_i,
   input  logic  start_i,
   input  logic  adv_i,
   output logic  g_o
);

   localparam int BW = $clog2(2 * BURST);
   localparam logic [BW-1:0] BLAST = BW'(2 * BURST - 1);
   localparam logic [BW-1:0] BON   = BW'(BURST);

   logic [7:0]    lfsr_q, lfsr_d;
   logic          tog_q, tog_d;
   logic [BW-1:0] bcnt_q, bcnt_d;

   // LFSR is free-running across runs; only reset reseeds it
   always_comb begin
      lfsr_d = lfsr_q;
      tog_d  = tog_q;
      bcnt_d = bcnt_q;
      if (adv_i) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
      if (start_i) begin
         tog_d  = 1'b1;
         bcnt_d = '0;
      end else if (adv_i) begin
         tog_d  = ~tog_q;
         bcnt_d = (bcnt_q == BLAST) ? '0 : bcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
         tog_q  <= 1'b1;
         bcnt_q <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         tog_q  <= tog_d;
         bcnt_q <= bcnt_d;
      end
   end

   always_comb begin
      g_o = 1'b1;
      unique case (mode_i)
         M_CONT:  g_o = 1'b1;
         M_ALT:   g_o = tog_q;
         M_LFSR:  g_o = lfsr_q[0];
         M_BURST: g_o = (bcnt_q < BON);
         default: g_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/vin_pattern_gen.sv
// Preloaded-sample stimulus source for the filter DIN/VIN input.
// Ports: CLK, RST_n, write port, NSAMP/MODE/START, BUSY, vin bundle.
module vin_pattern_gen
   import vin_pattern_gen_pkg::*;
#(
   parameter int                 NB    = NB_DEF,
   parameter int                 DEPTH = 64,
   parameter int                 AW    = 6,
   parameter int                 BURST = 4,
   parameter int                 DRAIN = 8,
   parameter logic signed [NB-1:0] C2  = '0,
   parameter logic signed [NB-1:0] C1  = '0,
   parameter logic signed [NB-1:0] C0  = '0,
   parameter logic signed [NB-1:0] B0  = '0,
   parameter logic [7:0]         SEED  = 8'hA5
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic                 WE,
   input  logic [AW-1:0]        WADDR,
   input  logic signed [NB-1:0] WDATA,
   input  logic [AW:0]          NSAMP,
   input  logic [1:0]           MODE,
   input  logic                 START,
   output logic                 BUSY,
   vin_pattern_gen_if.master    vin
);

   localparam int DW = $clog2(DRAIN + 2);
   localparam logic [AW:0]   DEPTH_N = (AW + 1)'(DEPTH);
   localparam logic [DW-1:0] DRAIN_N = DW'(DRAIN);

   state_e               state_q, state_d;
   logic                 vout_q, vout_d;
   logic signed [NB-1:0] dout_q, dout_d;
   logic [AW-1:0]        rd_q, rd_d;
   logic [AW:0]          sent_q, sent_d;
   logic [AW:0]          n_q, n_d;
   mode_e                mode_q, mode_d;
   logic [DW-1:0]        dcnt_q, dcnt_d;
   logic                 g, go, run;

   logic signed [NB-1:0] mem [DEPTH];

   assign run = (state_q == S_RUN);
   assign go  = START &&
                (state_q == S_IDLE || state_q == S_DONE);

   always_ff @(posedge CLK) begin
      if (WE && state_q == S_IDLE) begin
         mem[WADDR] <= WDATA;
      end
   end

   gap_gen #(
      .BURST (BURST),
      .SEED  (SEED)
   ) u_gap (
      .clk     (CLK),
      .rst_n   (RST_n),
      .mode_i  (mode_q),
      .start_i (go),
      .adv_i   (run),
      .g_o     (g)
   );

   always_comb begin
      state_d = state_q;
      vout_d  = 1'b0;
      dout_d  = dout_q;
      rd_d    = rd_q;
      sent_d  = sent_q;
      n_d     = n_q;
      mode_d  = mode_q;
      dcnt_d  = dcnt_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (START) begin
               state_d = S_RUN;
               mode_d  = mode_e'(MODE);
               rd_d    = '0;
               sent_d  = '0;
               // 0 and anything beyond the memory mean "all of it"
               if (NSAMP == '0 || NSAMP > DEPTH_N) begin
                  n_d = DEPTH_N;
               end else begin
                  n_d = NSAMP;
               end
            end
         end
         S_RUN: begin
            if (g) begin
               vout_d = 1'b1;
               dout_d = mem[rd_q];
               rd_d   = rd_q + 1'b1;
               sent_d = sent_q + 1'b1;
               if (sent_d == n_q) begin
                  state_d = S_DRAIN;
                  dcnt_d  = '0;
               end
            end
         end
         S_DRAIN: begin
            // first DRAIN cycle still shows the last VOUT
            if (dcnt_q == DRAIN_N) begin
               state_d = S_DONE;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= S_IDLE;
         vout_q  <= 1'b0;
         dout_q  <= '0;
         rd_q    <= '0;
         sent_q  <= '0;
         n_q     <= DEPTH_N;
         mode_q  <= M_CONT;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         vout_q  <= vout_d;
         dout_q  <= dout_d;
         rd_q    <= rd_d;
         sent_q  <= sent_d;
         n_q     <= n_d;
         mode_q  <= mode_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign BUSY        = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign vin.VOUT    = vout_q;
   assign vin.DOUT    = dout_q;
   assign vin.END_SIM = (state_q == S_DONE);
   assign vin.c2      = C2;
   assign vin.c1      = C1;
   assign vin.c0      = C0;
   assign vin.b0      = B0;

endmodule

// File: doc/vin_pattern_gen.md
Name: vin_pattern_gen

Overview:
Synthesizable stimulus transmitter that drives the filter's DIN/VIN input interface. It lets the valid-input test run on silicon or FPGA without a file-based data maker.
Samples are preloaded into an internal memory through a write port. On START they are streamed out, and VOUT is gated by a selectable gap pattern: continuous, alternate, pseudo-random or burst.
Static coefficient outputs and an END_SIM flag complete the same interface the filter and the data sink already consume.

Parameters:
NB, 11, sample/coefficient width in bits
DEPTH, 64, sample memory depth (power of 2)
AW, 6, address width, log2(DEPTH)
BURST, 4, valid/idle run length in burst mode
DRAIN, 8, cycles after the last valid sample before END_SIM rises
C2, 11'sd0, coefficient value driven on c2
C1, 11'sd0, coefficient value driven on c1
C0, 11'sd0, coefficient value driven on c0
B0, 11'sd0, coefficient value driven on b0
SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
CLK  in  1  clock, all state on rising edge
RST_n  in  1  asynchronous active-low reset
WE  in  1  sample memory write enable, honoured only in IDLE
WADDR  in  AW  write address
WDATA  in  NB  write data (signed)
NSAMP  in  AW+1  number of samples to send, 1..DEPTH; sampled on START
MODE  in  2  gap pattern: 0 continuous, 1 alternate, 2 LFSR, 3 burst; sampled on START
START  in  1  single-cycle start pulse, honoured only in IDLE or DONE
VOUT  out  1  valid strobe to the filter's VIN
DOUT  out  NB  sample to the filter's DIN
c2, c1, c0, b0  out  NB each  constant coefficients from parameters
BUSY  out  1  high in RUN and DRAIN
END_SIM  out  1  high in DONE

Behaviour:
- Reset (RST_n=0, asynchronous):
  - state=IDLE, VOUT=0, DOUT=0, END_SIM=0, BUSY=0.
  - rd_ptr=0, sent=0, LFSR=SEED, burst counter=0.
  - Memory contents are not reset.
- Reset asserted mid-RUN aborts immediately. The next START after release restarts from address 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - WE writes WDATA to mem[WADDR].
  - START latches NSAMP and MODE, clears rd_ptr, sent and burst counter, then goes to RUN.
- RUN, per cycle:
  - Gate g is computed from MODE:
    - mode 0: g=1.
    - mode 1: g toggles every cycle, first RUN cycle g=1.
    - mode 2: g=LFSR[0].
    - mode 3: g=1 for BURST cycles, then 0 for BURST cycles, repeating.
  - LFSR is 8-bit Fibonacci, taps 8,6,5,4, and advances every RUN cycle in every mode.
  - If g=1: next cycle VOUT=1, DOUT=mem[rd_ptr], rd_ptr+1, sent+1.
  - If g=0: next cycle VOUT=0 and DOUT holds its last value.
  - Outputs are registered: latency from the START edge to the first possible VOUT is 1 cycle.
  - When sent reaches the latched NSAMP on a valid cycle, go to DRAIN. The last VOUT is exactly NSAMP valid pulses in total.
- DRAIN: VOUT=0, counts DRAIN cycles, then DONE.
- DONE:
  - END_SIM=1 and holds.
  - START returns to RUN, clearing END_SIM on the same edge.
  - WE is ignored.
- Boundary conditions:
  - NSAMP=0 is treated as DEPTH.
  - NSAMP>DEPTH is clamped to DEPTH.
  - rd_ptr wraps modulo DEPTH.
  - START during RUN/DRAIN is ignored.
  - WE and START in the same IDLE cycle: the write completes and the run starts. A write to address 0 is visible as the first sample.
- No backpressure: the filter always accepts when VOUT=1.
- Coefficient outputs are constant, including during reset.

Decomposition:
- Shared package: NB, state encoding (IDLE/RUN/DRAIN/DONE), MODE encodings, LFSR tap mask.
- One sub-module, gap_gen: takes MODE, run-start pulse and advance enable; produces g. It contains the LFSR, the toggle flop and the burst counter.
- Memory is an inferred register array in the top level.

Test Plan:
- Load mem[0..4]=1,-2,3,-4,5; NSAMP=5, MODE=0, START → VOUT high 5 consecutive cycles starting 1 cycle after START, DOUT=1,-2,3,-4,5; END_SIM rises DRAIN+1 cycles after the last valid.
- Same data, MODE=1 → VOUT pattern 1,0,1,0,1,0,1,0,1; DOUT held during gaps; exactly 5 valids.
- MODE=3, BURST=4, NSAMP=10 → valid groups 4,4,2 separated by 4 idle cycles; DOUT sequence follows mem order.
- MODE=2, SEED=A5, NSAMP=20 → VOUT matches the reference LFSR model cycle by cycle; 20 valids total; DOUT sequence mem[0..19].
- RST_n pulsed low after 3 valids in RUN → VOUT=0, BUSY=0 immediately; a new START sends from mem[0].
- NSAMP=0 with DEPTH=64 → 64 valids, rd_ptr wraps to 0; START issued during RUN is ignored; START in DONE reruns and clears END_SIM.
